// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg
//   Shared constants for the HPS PIO command sequencer: the command opcodes
//   carried in PIO_CONTROL_IN[20:15], the err_code values reported back to the
//   HPS, and the sequencer state encoding.
package pio_cmd_pkg;

  localparam logic [5:0] CMD_WRITE_IMGRAM  = 6'h01;
  localparam logic [5:0] CMD_WRITE_REGCTRL = 6'h02;
  localparam logic [5:0] CMD_START_PROCESS = 6'h04;
  localparam logic [5:0] CMD_CLEAR_STATUS  = 6'h08;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_ADDR    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_EXEC      = 2'd1;
  localparam logic [1:0] ST_PROC_WAIT = 2'd2;
  localparam logic [1:0] ST_ACK       = 2'd3;

endpackage

// File: rtl/pio_enable_edge.sv
// pio_enable_edge
//   Registers the PIO command word once and detects the rising edge of
//   ENABLE on the registered copy.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              raw hps_enable
//   cmd/address/data    raw PIO command fields
//   en_q                registered enable
//   rise                one-cycle pulse: en_q=1, previous en_q=0, armed
//   cmd_q/address_q/data_q  registered command fields
module pio_enable_edge #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [5:0]        cmd,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data,
  output logic              en_q,
  output logic              rise,
  output logic [5:0]        cmd_q,
  output logic [ADDR_W-1:0] address_q,
  output logic [31:0]       data_q
);

  logic en_qq;
  logic armed;

  // armed only sets once ENABLE has been seen low after reset, so an ENABLE
  // that is already high when reset releases never counts as a command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      en_qq     <= 1'b0;
      armed     <= 1'b0;
      cmd_q     <= '0;
      address_q <= '0;
      data_q    <= '0;
    end else begin
      en_q      <= enable;
      en_qq     <= en_q;
      armed     <= armed | ~enable;
      cmd_q     <= cmd;
      address_q <= address;
      data_q    <= data;
    end
  end

  assign rise = en_q & ~en_qq & armed;

endmodule

// File: rtl/pio_command_sequencer.sv
// pio_command_sequencer
//   Converts level-based HPS PIO commands into one registered single-cycle
//   action per ENABLE assertion (ImgRam write, RegisterController write,
//   processing start or status clear), then holds hps_done until the HPS
//   drops ENABLE. Includes address range checking, a processing watchdog
//   and a saturating ImgRam write counter.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   hps_enable/cmd/address/data     PIO command inputs
//   img_wren/wraddress/data         ImgRam write port
//   reg_write/address/writedata     RegisterController write port
//   proc_enable, proc_done          Controller start level / done input
//   hps_done, hps_error, busy       status to HPS
//   err_code                        0 none, 1 bad cmd, 2 bad addr, 3 timeout
//   img_write_count                 successful ImgRam writes (saturating)
module pio_command_sequencer
  import pio_cmd_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter int IMG_DEPTH      = 19200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hps_enable,
  input  logic [5:0]        hps_cmd,
  input  logic [ADDR_W-1:0] hps_address,
  input  logic [31:0]       hps_data,
  output logic              img_wren,
  output logic [ADDR_W-1:0] img_wraddress,
  output logic [7:0]        img_data,
  output logic              reg_write,
  output logic [1:0]        reg_address,
  output logic [31:0]       reg_writedata,
  output logic              proc_enable,
  input  logic              proc_done,
  output logic              hps_done,
  output logic              hps_error,
  output logic              busy,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] img_write_count
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]       IMG_DEPTH_W = 32'(IMG_DEPTH);
  localparam logic [ADDR_W-1:0] COUNT_MAX   = '1;

  logic              en_q;
  logic              rise;
  logic [5:0]        cmd_q;
  logic [ADDR_W-1:0] address_q;
  logic [31:0]       data_q;

  logic [1:0]        state;
  logic [5:0]        cmd_l;
  logic [ADDR_W-1:0] addr_l;
  logic [31:0]       data_l;
  logic [WD_W-1:0]   watchdog;
  logic              addr_ok;

  pio_enable_edge #(.ADDR_W(ADDR_W)) u_edge (
    .clk       (clk),
    .reset     (reset),
    .enable    (hps_enable),
    .cmd       (hps_cmd),
    .address   (hps_address),
    .data      (hps_data),
    .en_q      (en_q),
    .rise      (rise),
    .cmd_q     (cmd_q),
    .address_q (address_q),
    .data_q    (data_q)
  );

  assign addr_ok = ({{(32-ADDR_W){1'b0}}, addr_l} < IMG_DEPTH_W);
  assign busy    = (state != ST_IDLE);

  // Main sequencer. Strobes default low each cycle so every action is a
  // single-cycle pulse. hps_done is raised on the first ACK cycle regardless
  // of ENABLE, so a command whose ENABLE was dropped early still produces a
  // one-cycle done pulse before returning to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      cmd_l           <= '0;
      addr_l          <= '0;
      data_l          <= '0;
      watchdog        <= '0;
      img_wren        <= 1'b0;
      img_wraddress   <= '0;
      img_data        <= '0;
      reg_write       <= 1'b0;
      reg_address     <= '0;
      reg_writedata   <= '0;
      proc_enable     <= 1'b0;
      hps_done        <= 1'b0;
      hps_error       <= 1'b0;
      err_code        <= ERR_NONE;
      img_write_count <= '0;
    end else begin
      img_wren  <= 1'b0;
      reg_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            cmd_l     <= cmd_q;
            addr_l    <= address_q;
            data_l    <= data_q;
            err_code  <= ERR_NONE;
            hps_error <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_ACK;
          case (cmd_l)
            CMD_WRITE_IMGRAM: begin
              if (addr_ok) begin
                img_wren      <= 1'b1;
                img_wraddress <= addr_l;
                img_data      <= data_l[7:0];
                if (img_write_count != COUNT_MAX)
                  img_write_count <= img_write_count + ADDR_W'(1);
              end else begin
                err_code <= ERR_ADDR;
              end
            end
            CMD_WRITE_REGCTRL: begin
              reg_write     <= 1'b1;
              reg_address   <= addr_l[1:0];
              reg_writedata <= data_l;
            end
            CMD_START_PROCESS: begin
              proc_enable <= 1'b1;
              watchdog    <= '0;
              state       <= ST_PROC_WAIT;
            end
            CMD_CLEAR_STATUS: begin
              img_write_count <= '0;
            end
            default: begin
              err_code <= ERR_CMD;
            end
          endcase
        end
        ST_PROC_WAIT: begin
          // done is checked first so a simultaneous timeout reports success
          if (proc_done) begin
            proc_enable <= 1'b0;
            state       <= ST_ACK;
          end else if (watchdog == WD_LAST) begin
            proc_enable <= 1'b0;
            err_code    <= ERR_TIMEOUT;
            state       <= ST_ACK;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        ST_ACK: begin
          if (!hps_done) begin
            hps_done  <= 1'b1;
            hps_error <= (err_code != ERR_NONE);
          end else if (!en_q) begin
            hps_done <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_command_sequencer.sv
// tb_pio_command_sequencer
//   Directed plus randomized bench for pio_command_sequencer. A small
//   behavioural model (expected strobe, error code, counter and held output
//   values per command) is derived from the command rules and compared at
//   fixed offsets from the ENABLE assertion.
module tb_pio_command_sequencer;

  localparam int ADDR_W    = 15;
  localparam int IMG_DEPTH = 19200;
  localparam int TIMEOUT   = 64;

  logic              clk;
  logic              reset;
  logic              hps_enable;
  logic [5:0]        hps_cmd;
  logic [ADDR_W-1:0] hps_address;
  logic [31:0]       hps_data;
  logic              img_wren;
  logic [ADDR_W-1:0] img_wraddress;
  logic [7:0]        img_data;
  logic              reg_write;
  logic [1:0]        reg_address;
  logic [31:0]       reg_writedata;
  logic              proc_enable;
  logic              proc_done;
  logic              hps_done;
  logic              hps_error;
  logic              busy;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] img_write_count;

  int tests;
  int failed;

  // reference model state
  logic [ADDR_W-1:0] m_count;
  logic [ADDR_W-1:0] m_img_addr;
  logic [7:0]        m_img_data;
  logic [1:0]        m_reg_addr;
  logic [31:0]       m_reg_data;

  pio_command_sequencer #(
    .ADDR_W(ADDR_W), .IMG_DEPTH(IMG_DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .hps_enable      (hps_enable),
    .hps_cmd         (hps_cmd),
    .hps_address     (hps_address),
    .hps_data        (hps_data),
    .img_wren        (img_wren),
    .img_wraddress   (img_wraddress),
    .img_data        (img_data),
    .reg_write       (reg_write),
    .reg_address     (reg_address),
    .reg_writedata   (reg_writedata),
    .proc_enable     (proc_enable),
    .proc_done       (proc_done),
    .hps_done        (hps_done),
    .hps_error       (hps_error),
    .busy            (busy),
    .err_code        (err_code),
    .img_write_count (img_write_count)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Hard stop in case the run ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=stalled expected=finish");
    $fatal(1, "[TB] run did not finish");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, 32'({img_wren, reg_write, proc_enable, hps_done, hps_error, busy}), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_code), 32'd0);
    checkOutput({tag, "_count"}, 32'(img_write_count), 32'd0);
    checkOutput({tag, "_img"}, 32'({img_wraddress, img_data}), 32'd0);
    checkOutput({tag, "_reg"}, 32'(reg_address) | reg_writedata, 32'd0);
  endtask

  // Issue one command and follow it through to IDLE. done_at is the index of
  // the PROC_WAIT cycle in which proc_done is driven (>= TIMEOUT: never);
  // hold is the number of extra cycles ENABLE stays high after hps_done.
  task automatic applyStimulus(input logic [5:0] c, input logic [ADDR_W-1:0] a,
                               input logic [31:0] d, input int done_at, input int hold);
    bit exp_img, exp_reg, exp_proc, ended;
    int exp_err;
    exp_img  = (c == 6'h01) && (int'(a) < IMG_DEPTH);
    exp_reg  = (c == 6'h02);
    exp_proc = (c == 6'h04);
    if (c == 6'h01)      exp_err = exp_img ? 0 : 2;
    else if (exp_proc)   exp_err = (done_at < TIMEOUT) ? 0 : 3;
    else if (c == 6'h02 || c == 6'h08) exp_err = 0;
    else                 exp_err = 1;

    hps_enable  = 1'b1;
    hps_cmd     = c;
    hps_address = a;
    hps_data    = d;
    tick;  // E0
    tick;  // E1
    checkOutput("e1_busy", 32'(busy), 32'd1);
    checkOutput("e1_strobes", 32'({img_wren, reg_write, proc_enable}), 32'd0);
    tick;  // E2
    checkOutput("e2_img_wren", 32'(img_wren), 32'(exp_img));
    checkOutput("e2_reg_write", 32'(reg_write), 32'(exp_reg));
    checkOutput("e2_proc_enable", 32'(proc_enable), 32'(exp_proc));
    if (exp_img) begin
      checkOutput("e2_img_addr", 32'(img_wraddress), 32'(a));
      checkOutput("e2_img_data", 32'(img_data), 32'(d[7:0]));
    end
    if (exp_proc) begin
      for (int j = 0; j < TIMEOUT; j++) begin
        if (j == done_at) proc_done = 1'b1;
        tick;
        proc_done = 1'b0;
        ended = (j == done_at) || (j == TIMEOUT - 1);
        checkOutput("proc_enable_run", 32'(proc_enable), 32'(!ended));
        if (ended) break;
      end
    end

    if (exp_img) begin
      if (m_count != '1) m_count = m_count + 1'b1;
      m_img_addr = a;
      m_img_data = d[7:0];
    end
    if (exp_reg) begin
      m_reg_addr = a[1:0];
      m_reg_data = d;
    end
    if (c == 6'h08) m_count = '0;

    tick;  // first ACK cycle
    checkOutput("ack_done", 32'(hps_done), 32'd1);
    checkOutput("ack_error", 32'(hps_error), 32'(exp_err != 0));
    checkOutput("ack_err_code", 32'(err_code), 32'(exp_err));
    checkOutput("ack_strobes", 32'({img_wren, reg_write, proc_enable}), 32'd0);
    checkOutput("ack_count", 32'(img_write_count), 32'(m_count));
    checkOutput("ack_img_hold", 32'({img_wraddress, img_data}), 32'({m_img_addr, m_img_data}));
    checkOutput("ack_reg_addr", 32'(reg_address), 32'(m_reg_addr));
    checkOutput("ack_reg_data", reg_writedata, m_reg_data);
    for (int k = 0; k < hold; k++) begin
      tick;
      checkOutput("hold_done", 32'(hps_done), 32'd1);
      checkOutput("hold_strobes", 32'({img_wren, reg_write}), 32'd0);
    end
    hps_enable = 1'b0;
    tick;
    checkOutput("drop_done", 32'(hps_done), 32'd1);
    tick;
    checkOutput("release_done", 32'(hps_done), 32'd0);
    checkOutput("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [5:0]        c;
    logic [ADDR_W-1:0] a;
    tests = 0;
    failed = 0;
    m_count = '0; m_img_addr = '0; m_img_data = '0; m_reg_addr = '0; m_reg_data = '0;
    reset = 1'b1;
    hps_enable = 1'b0; hps_cmd = '0; hps_address = '0; hps_data = '0; proc_done = 1'b0;

    #25;
    checkAllZero("reset");
    tick;
    reset = 1'b0;
    tick;
    checkAllZero("post_reset");

    // directed commands
    applyStimulus(6'h01, 15'd5, 32'h0000_00AB, 0, 2);
    applyStimulus(6'h01, 15'd19200, 32'h0000_0011, 0, 0);
    applyStimulus(6'h01, 15'd19199, 32'h0000_0022, 0, 1);
    applyStimulus(6'h02, 15'd3, 32'hDEAD_BEEF, 0, 100);
    applyStimulus(6'h04, 15'd0, 32'h0, 50, 1);
    applyStimulus(6'h04, 15'd0, 32'h0, 1000, 0);
    applyStimulus(6'h04, 15'd0, 32'h0, TIMEOUT - 1, 0);
    applyStimulus(6'h3F, 15'd0, 32'h0, 0, 0);
    applyStimulus(6'h00, 15'd0, 32'h0, 0, 0);
    applyStimulus(6'h08, 15'd0, 32'h0, 0, 0);

    // ENABLE dropped while processing: done still completes, one-cycle pulse
    hps_enable = 1'b1; hps_cmd = 6'h04;
    tick; tick; tick;
    checkOutput("drop_proc_start", 32'(proc_enable), 32'd1);
    hps_enable = 1'b0;
    repeat (10) tick;
    checkOutput("drop_proc_still", 32'(proc_enable), 32'd1);
    proc_done = 1'b1;
    tick;
    proc_done = 1'b0;
    checkOutput("drop_proc_end", 32'(proc_enable), 32'd0);
    tick;
    checkOutput("drop_proc_done", 32'(hps_done), 32'd1);
    tick;
    checkOutput("drop_proc_done_clr", 32'(hps_done), 32'd0);
    checkOutput("drop_proc_idle", 32'(busy), 32'd0);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    c = 6'h01;
        2:       c = 6'h02;
        3:       c = 6'h04;
        4:       c = 6'h08;
        default: c = 6'($urandom) | 6'h30;
      endcase
      case ($urandom_range(0, 3))
        0:       a = ADDR_W'($urandom_range(0, IMG_DEPTH - 1));
        1:       a = ADDR_W'(IMG_DEPTH - 1);
        2:       a = ADDR_W'(IMG_DEPTH);
        default: a = ADDR_W'($urandom_range(IMG_DEPTH, 32767));
      endcase
      applyStimulus(c, a, $urandom, int'($urandom_range(0, 70)), int'($urandom_range(0, 3)));
    end

    // reset during PROC_WAIT with ENABLE held through release
    hps_enable = 1'b1; hps_cmd = 6'h04;
    tick; tick; tick;
    repeat (5) tick;
    checkOutput("pre_reset_proc", 32'(proc_enable), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    tick;
    reset = 1'b0;
    m_count = '0; m_img_addr = '0; m_img_data = '0; m_reg_addr = '0; m_reg_data = '0;
    for (int k = 0; k < 8; k++) begin
      tick;
      checkOutput("held_enable_idle", 32'({busy, proc_enable, img_wren, reg_write, hps_done}), 32'd0);
    end
    hps_enable = 1'b0;
    tick; tick;
    applyStimulus(6'h01, 15'd7, 32'h0000_0055, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
